// File: rtl/ws2812b_frame_sequencer.sv
// WS2812B frame sequencer: serialises GRB pixel words MSB-first to the NRZ encoder, then holds the latch interval.
// Optional build macro WS2812B_BRIGHTNESS_EN adds brightness[7:0], which scales each channel when a word is captured.
//
// state | meaning
// IDLE  | waiting for start
// LOAD  | waiting for the first pixel word of the frame
// SEND  | serialising the shift register, prefetching the next word into hold
// LATCH | line held low for the reset interval, then frame_done
module ws2812b_frame_sequencer #(
   parameter int LED_COUNT             = 8,
   parameter int BITS_PER_LED          = 24,
   parameter int BIT_PERIOD_CLK_COUNTS = 63,
   parameter int LATCH_CLK_COUNTS      = 2500
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic                    start,
   input  logic [BITS_PER_LED-1:0] pixel_data,
   input  logic                    pixel_valid,
`ifdef WS2812B_BRIGHTNESS_EN
   input  logic [7:0]              brightness,
`endif
   output logic                    pixel_ready,
   output logic                    bit_trigger,
   output logic                    bit_to_code,
   output logic                    busy,
   output logic                    frame_done,
   output logic                    underrun
);

   localparam int LED_W = (LED_COUNT > 1) ? $clog2(LED_COUNT) : 1;
   localparam int ACC_W = $clog2(LED_COUNT + 1);
   localparam int BIT_W = (BITS_PER_LED > 1) ? $clog2(BITS_PER_LED) : 1;
   localparam int TMR_W = (BIT_PERIOD_CLK_COUNTS > 1) ? $clog2(BIT_PERIOD_CLK_COUNTS) : 1;
   localparam int LAT_W = (LATCH_CLK_COUNTS > 1) ? $clog2(LATCH_CLK_COUNTS) : 1;

   localparam logic [LED_W-1:0] LED_LAST = LED_W'(LED_COUNT - 1);
   localparam logic [ACC_W-1:0] ACC_MAX  = ACC_W'(LED_COUNT);
   localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(BITS_PER_LED - 1);
   localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(BIT_PERIOD_CLK_COUNTS - 1);
   localparam logic [LAT_W-1:0] LAT_LAST = LAT_W'(LATCH_CLK_COUNTS - 1);

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_LOAD  = 2'd1;
   localparam logic [1:0] S_SEND  = 2'd2;
   localparam logic [1:0] S_LATCH = 2'd3;

   logic [1:0]              state;
   logic [BITS_PER_LED-1:0] shift;
   logic [BITS_PER_LED-1:0] hold;
   logic                    hold_full;
   logic [BIT_W-1:0]        bit_idx;
   logic [TMR_W-1:0]        bit_timer;
   logic [LED_W-1:0]        led_idx;
   logic [ACC_W-1:0]        words_accepted;
   logic [LAT_W-1:0]        latch_timer;
   logic [BITS_PER_LED-1:0] captured;
   logic                    xfer;
   logic                    wrap;
   logic                    last_bit;

`ifdef WS2812B_BRIGHTNESS_EN
   // Per channel: (c * (brightness + 1)) >> 8, truncating.
   always_comb begin
      captured = pixel_data;
      for (int ch = 0; ch < BITS_PER_LED / 8; ch++) begin
         captured[ch*8 +: 8] = 8'(({8'd0, pixel_data[ch*8 +: 8]} * ({8'd0, brightness} + 16'd1)) >> 8);
      end
   end
`else
   assign captured = pixel_data;
`endif

   always_comb begin
      pixel_ready = 1'b0;
      case (state)
         S_LOAD:  pixel_ready = 1'b1;
         S_SEND:  pixel_ready = !hold_full && (words_accepted < ACC_MAX);
         default: pixel_ready = 1'b0;
      endcase
   end

   assign xfer        = pixel_valid && pixel_ready;
   assign wrap        = (bit_timer == TMR_LAST);
   assign last_bit    = (bit_idx == BIT_LAST);
   assign bit_trigger = (state == S_SEND) && (bit_timer == '0);
   assign busy        = (state != S_IDLE);

   always_ff @(posedge clk) begin
      if (reset) begin
         state          <= S_IDLE;
         shift          <= '0;
         hold           <= '0;
         hold_full      <= 1'b0;
         bit_idx        <= '0;
         bit_timer      <= '0;
         led_idx        <= '0;
         words_accepted <= '0;
         latch_timer    <= '0;
         bit_to_code    <= 1'b0;
         frame_done     <= 1'b0;
         underrun       <= 1'b0;
      end else begin
         frame_done <= 1'b0;
         underrun   <= 1'b0;
         case (state)
            S_IDLE: begin
               if (start) begin
                  state          <= S_LOAD;
                  words_accepted <= '0;
                  led_idx        <= '0;
                  hold_full      <= 1'b0;
               end
            end
            S_LOAD: begin
               if (xfer) begin
                  shift          <= captured;
                  bit_to_code    <= captured[BITS_PER_LED-1];
                  bit_idx        <= '0;
                  bit_timer      <= '0;
                  words_accepted <= words_accepted + 1'b1;
                  state          <= S_SEND;
               end
            end
            S_SEND: begin
               if (xfer) begin
                  hold           <= captured;
                  hold_full      <= 1'b1;
                  words_accepted <= words_accepted + 1'b1;
               end
               if (wrap) begin
                  bit_timer <= '0;
                  if (!last_bit) begin
                     shift       <= {shift[BITS_PER_LED-2:0], 1'b0};
                     bit_to_code <= shift[BITS_PER_LED-2];
                     bit_idx     <= bit_idx + 1'b1;
                  end else if (led_idx == LED_LAST) begin
                     state       <= S_LATCH;
                     latch_timer <= '0;
                     bit_to_code <= 1'b0;
                  end else if (hold_full) begin
                     // Next pixel starts on the very next cycle, no gap on the line.
                     shift       <= hold;
                     bit_to_code <= hold[BITS_PER_LED-1];
                     hold_full   <= 1'b0;
                     led_idx     <= led_idx + 1'b1;
                     bit_idx     <= '0;
                  end else begin
                     state       <= S_LATCH;
                     latch_timer <= '0;
                     bit_to_code <= 1'b0;
                     underrun    <= 1'b1;
                  end
               end else begin
                  bit_timer <= bit_timer + 1'b1;
               end
            end
            default: begin
               if (latch_timer == LAT_LAST) begin
                  frame_done <= 1'b1;
                  state      <= S_IDLE;
               end else begin
                  latch_timer <= latch_timer + 1'b1;
               end
            end
         endcase
      end
   end

endmodule

// File: tb/tb_ws2812b_frame_sequencer.sv
// Bench for ws2812b_frame_sequencer: frame-level reference model compared every cycle, plus literal frame checks.
module tb_ws2812b_frame_sequencer;

   localparam int LEDS    = 3;
   localparam int BITS    = 24;
   localparam int BP      = 63;
   localparam int LAT     = 2500;
   localparam int PIX_CYC = BITS * BP;

   logic        clk = 1'b0;
   logic        reset, start, pixel_valid;
   logic [23:0] pixel_data;
   logic        pixel_ready, bit_trigger, bit_to_code, busy, frame_done, underrun;
`ifdef WS2812B_BRIGHTNESS_EN
   logic [7:0]  brightness = 8'd127;
`endif

   always #5 clk = ~clk;

   ws2812b_frame_sequencer #(
      .LED_COUNT(LEDS), .BITS_PER_LED(BITS),
      .BIT_PERIOD_CLK_COUNTS(BP), .LATCH_CLK_COUNTS(LAT)
   ) dut (
      .clk(clk), .reset(reset), .start(start),
      .pixel_data(pixel_data), .pixel_valid(pixel_valid),
`ifdef WS2812B_BRIGHTNESS_EN
      .brightness(brightness),
`endif
      .pixel_ready(pixel_ready), .bit_trigger(bit_trigger), .bit_to_code(bit_to_code),
      .busy(busy), .frame_done(frame_done), .underrun(underrun)
   );

   int checks = 0;
   int errors = 0;
   int cyc = 0;

   task automatic chk(input string name, input longint act, input longint exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   function automatic logic [23:0] scale(input logic [23:0] w);
      logic [23:0] r;
      r = w;
`ifdef WS2812B_BRIGHTNESS_EN
      for (int c = 0; c < 3; c++)
         r[c*8 +: 8] = 8'((int'(w[c*8 +: 8]) * (int'(brightness) + 1)) / 256);
`endif
      return r;
   endfunction

   // Model: phase 0 idle, 1 waiting first word, 2 sending, 3 latching; m_t counts cycles in phase.
   int          m_ph = 0, m_t = 0, m_acc = 0;
   logic [23:0] m_words [LEDS];
   bit          m_fd = 0, m_ur = 0;
   int          pix, acc_before;
   bit          e_ready, e_trig, e_code;

   // Per-frame observations, cleared when a start is honoured.
   int          f_trig = 0, f_xfer = 0, f_ur = 0, f_fd = 0;
   int          f_start_cyc = 0, f_t1 = 0, f_t2 = 0, f_ur_cyc = 0, f_fd_cyc = 0;
   logic [23:0] f_bits = '0;

   initial begin
      foreach (m_words[i]) m_words[i] = '0;
      forever begin
         @(negedge clk);
         cyc++;
         pix     = (m_ph == 2) ? m_t / PIX_CYC : 0;
         e_ready = (m_ph == 1) || (m_ph == 2 && m_acc == pix + 1 && m_acc < LEDS);
         e_trig  = (m_ph == 2) && (m_t % BP == 0);
         e_code  = (m_ph == 2) ? m_words[pix][BITS - 1 - (m_t / BP) % BITS] : 1'b0;
         chk("busy", longint'(busy), longint'(m_ph != 0));
         chk("pixel_ready", longint'(pixel_ready), longint'(e_ready));
         chk("bit_trigger", longint'(bit_trigger), longint'(e_trig));
         chk("bit_to_code", longint'(bit_to_code), longint'(e_code));
         chk("frame_done", longint'(frame_done), longint'(m_fd));
         chk("underrun", longint'(underrun), longint'(m_ur));

         if (m_ph == 0 && start && !reset) begin
            f_trig = 0; f_xfer = 0; f_ur = 0; f_fd = 0; f_bits = '0;
            f_start_cyc = cyc;
         end
         if (bit_trigger) begin
            if (f_trig < 24) f_bits[23 - f_trig] = bit_to_code;
            if (f_trig == 0) f_t1 = cyc;
            if (f_trig == 1) f_t2 = cyc;
            f_trig++;
         end
         if (pixel_valid && pixel_ready) f_xfer++;
         if (underrun) begin f_ur++; f_ur_cyc = cyc; end
         if (frame_done) begin f_fd++; f_fd_cyc = cyc; end

         if (reset) begin
            m_ph = 0; m_fd = 0; m_ur = 0;
         end else begin
            m_fd = 0; m_ur = 0;
            case (m_ph)
               0: if (start) begin m_ph = 1; m_acc = 0; end
               1: if (pixel_valid) begin
                     m_words[0] = scale(pixel_data); m_acc = 1; m_ph = 2; m_t = 0;
                  end
               2: begin
                     acc_before = m_acc;
                     if (pixel_valid && e_ready) begin
                        m_words[m_acc] = scale(pixel_data); m_acc++;
                     end
                     if ((m_t + 1) % PIX_CYC == 0) begin
                        if (pix == LEDS - 1) begin m_ph = 3; m_t = 0; end
                        else if (acc_before > pix + 1) m_t++;
                        else begin m_ph = 3; m_t = 0; m_ur = 1; end
                     end else m_t++;
                  end
               default: if (m_t == LAT - 1) begin m_ph = 0; m_fd = 1; end else m_t++;
            endcase
         end
      end
   end

   logic [23:0] tb_words [LEDS];

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   // Pulse start, then offer words; word 0 from first_delay, later words from hold_cyc.
   // abort_trig>0 stops the loop once that many triggers have fired. poke pulses start in SEND and LATCH.
   task automatic run_frame(input int first_delay, input int hold_cyc, input int abort_trig, input bit poke);
      int  idx, n;
      bit  done;
      start = 1'b1;
      tick(1);
      start = 1'b0;
      idx = 0; n = 0; done = 0;
      while (!done && n < 12000) begin
         pixel_valid = (idx < LEDS) && ((idx == 0) ? (n >= first_delay) : (n >= hold_cyc));
         pixel_data  = tb_words[(idx < LEDS) ? idx : 0];
         start       = poke && (n == 700 || n == 3 * PIX_CYC + 200);
         @(negedge clk);
         #1;
         if (pixel_valid && pixel_ready) idx++;
         if (f_fd > 0) done = 1;
         if (abort_trig > 0 && f_trig >= abort_trig) done = 1;
         @(posedge clk);
         #1;
         n++;
      end
      chk("frame_timeout", longint'(done), 1);
      pixel_valid = 1'b0;
      start = 1'b0;
   endtask

   logic [23:0] exp_first;

   initial begin
      reset = 1'b1; start = 1'b0; pixel_valid = 1'b0; pixel_data = '0;
`ifdef WS2812B_BRIGHTNESS_EN
      tb_words[0] = 24'hFF8001; exp_first = 24'h7F4000;
`else
      tb_words[0] = 24'hA50000; exp_first = 24'hA50000;
`endif
      tb_words[1] = 24'h3C0FF0;
      tb_words[2] = 24'h81007E;
      tick(3);
      reset = 1'b0;
      @(negedge clk); #1;
      chk("rst_busy", longint'(busy), 0);
      chk("rst_ready", longint'(pixel_ready), 0);
      chk("rst_trigger", longint'(bit_trigger), 0);
      chk("rst_done", longint'(frame_done), 0);
      tick(1);

      // Full frame, words always valid.
      run_frame(0, 0, 0, 1'b0);
      chk("A_triggers", f_trig, 72);
      chk("A_transfers", f_xfer, 3);
      chk("A_done", f_fd, 1);
      chk("A_underrun", f_ur, 0);
      chk("A_first_bits", longint'(f_bits), longint'(exp_first));
      chk("A_start_to_trig", f_t1 - f_start_cyc, 2);
      chk("A_trig_spacing", f_t2 - f_t1, 63);
      chk("A_trig_to_done", f_fd_cyc - f_t1, 72 * 63 + 2500);
      tick(5);

      // Second word withheld past the first pixel's last bit.
      run_frame(0, 2 + PIX_CYC + 10, 0, 1'b0);
      chk("B_triggers", f_trig, 24);
      chk("B_underrun", f_ur, 1);
      chk("B_done", f_fd, 1);
      chk("B_transfers", f_xfer, 1);
      chk("B_ur_time", f_ur_cyc - f_t1, 1512);
      chk("B_trig_to_done", f_fd_cyc - f_t1, 1512 + 2500);
      tick(5);

      // Reset during bit 10, then a clean frame from pixel 0.
      run_frame(0, 0, 11, 1'b0);
      tick(3);
      reset = 1'b1;
      tick(1);
      reset = 1'b0;
      @(negedge clk); #1;
      chk("C_busy", longint'(busy), 0);
      chk("C_trigger", longint'(bit_trigger), 0);
      chk("C_ready", longint'(pixel_ready), 0);
      chk("C_no_done", f_fd, 0);
      tick(3);
      run_frame(0, 0, 0, 1'b0);
      chk("C_first_bits", longint'(f_bits), longint'(exp_first));
      chk("C_triggers", f_trig, 72);
      chk("C_done", f_fd, 1);
      tick(5);

      // First word late; start pulsed during SEND and LATCH is ignored.
      run_frame(5, 0, 0, 1'b1);
      chk("D_start_to_trig", f_t1 - f_start_cyc, 7);
      chk("D_done", f_fd, 1);
      chk("D_transfers", f_xfer, 3);
      tick(20);
      chk("D_single_done", f_fd, 1);
      chk("D_idle_busy", longint'(busy), 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
